mitm_read_sequencer: RTL

Parametrised next-generation MITM controller for Microwire-style serial EEPROM buses (start bit + 2-bit opcode + address + data). It drives the bus control block chunk by chunk and decides per transaction whether MISO data or the MOSI address is replaced. It adds address-match, alternate-transaction and address-redirect attack modes, plus a substitution counter, over the fixed-width single-mode predecessor. It sits between the mode-select/config registers and the bus control module.

---
 rtl/mitm_read_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mitm_read_sequencer.sv
// Chunk-by-chunk MITM sequencer for Microwire EEPROM reads: forward, substitute or redirect.
// Optional MITM_SEQ_READ_EN keeps substituting data words for sequential reads until comm_active falls.
module mitm_read_sequencer #(
  parameter int ADDR_BITS        = 8,
  parameter int DATA_BITS        = 8,
  parameter int BUF_SIZE         = 9,
  parameter int CHUNK_SIZE_WIDTH = $clog2(BUF_SIZE + 1),
  parameter int MODE_WIDTH       = 3,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                        sys_clk,
  input  logic                        rst_n,
  input  logic [MODE_WIDTH-1:0]       mode_select,
  input  logic [DATA_BITS-1:0]        fake_const,
  input  logic [ADDR_BITS-1:0]        target_addr,
  input  logic                        comm_active,
  input  logic                        bus_ready,
  input  logic [BUF_SIZE-1:0]         real_miso_data,
  input  logic [BUF_SIZE-1:0]         real_mosi_data,
  output logic                        cmd_next_chunk,
  output logic                        cmd_finish,
  output logic [CHUNK_SIZE_WIDTH-1:0] next_chunk_size,
  output logic                        fake_miso_select,
  output logic                        fake_mosi_select,
  output logic [BUF_SIZE-1:0]         fake_miso_data,
  output logic [BUF_SIZE-1:0]         fake_mosi_data,
  output logic [CNT_WIDTH-1:0]        sub_count
);

  typedef enum logic [3:0] {
    S_RESET, S_IDLE, S_INSTR_START, S_INSTR, S_ADDR_START, S_ADDR,
    S_DATA_START, S_DATA, S_FINISH_START, S_FINISH
  } state_t;

  localparam logic [MODE_WIDTH-1:0] MODE_SUB_ALL   = MODE_WIDTH'(1);
  localparam logic [MODE_WIDTH-1:0] MODE_SUB_HALF  = MODE_WIDTH'(2);
  localparam logic [MODE_WIDTH-1:0] MODE_SUB_MATCH = MODE_WIDTH'(3);
  localparam logic [MODE_WIDTH-1:0] MODE_REDIRECT  = MODE_WIDTH'(4);

  localparam logic [CHUNK_SIZE_WIDTH-1:0] SZ_INSTR = CHUNK_SIZE_WIDTH'(3);
  localparam logic [CHUNK_SIZE_WIDTH-1:0] SZ_ADDR  = CHUNK_SIZE_WIDTH'(ADDR_BITS + 1);
  localparam logic [CHUNK_SIZE_WIDTH-1:0] SZ_DATA  = CHUNK_SIZE_WIDTH'(DATA_BITS);
  localparam int MISO_SHIFT = BUF_SIZE - DATA_BITS;
  localparam int MOSI_SHIFT = BUF_SIZE - ADDR_BITS - 1;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  state_t                      state, state_nxt;
  logic [MODE_WIDTH-1:0]       mode_q, mode_nxt;
  logic                        half_toggle, half_nxt;
  logic                        next_nxt, fin_nxt, miso_sel_nxt, mosi_sel_nxt;
  logic [CHUNK_SIZE_WIDTH-1:0] size_nxt;
  logic [BUF_SIZE-1:0]         miso_data_nxt, mosi_data_nxt;
  logic [CNT_WIDTH-1:0]        cnt_nxt;
  logic [ADDR_BITS-1:0]        addr;
  logic                        is_read, do_sub;
  logic [BUF_SIZE-1:0]         miso_word, redir_word;
  logic                        unused_bits;

  assign addr       = real_mosi_data[ADDR_BITS:1];
  assign is_read    = (real_mosi_data[2:0] == 3'b110);
  assign miso_word  = BUF_SIZE'(fake_const) << MISO_SHIFT;
  assign redir_word = BUF_SIZE'({target_addr, 1'b0}) << MOSI_SHIFT;
  assign do_sub     = (mode_q == MODE_SUB_ALL)
                   || ((mode_q == MODE_SUB_HALF) && half_toggle)
                   || ((mode_q == MODE_SUB_MATCH) && (addr == target_addr));
  // MISO capture is passed through by bus control; the sequencer never inspects it.
  assign unused_bits = ^real_miso_data;

  always_comb begin
    state_nxt     = state;
    mode_nxt      = mode_q;
    half_nxt      = half_toggle;
    next_nxt      = 1'b0;
    fin_nxt       = 1'b0;
    size_nxt      = next_chunk_size;
    miso_sel_nxt  = fake_miso_select;
    mosi_sel_nxt  = fake_mosi_select;
    miso_data_nxt = fake_miso_data;
    mosi_data_nxt = fake_mosi_data;
    cnt_nxt       = sub_count;
    case (state)
      S_RESET: begin
        size_nxt      = '0;
        miso_sel_nxt  = 1'b0;
        mosi_sel_nxt  = 1'b0;
        miso_data_nxt = '0;
        mosi_data_nxt = '0;
        state_nxt     = S_IDLE;
      end
      S_IDLE: if (comm_active) begin
        mode_nxt     = mode_select;
        size_nxt     = SZ_INSTR;
        miso_sel_nxt = 1'b0;
        mosi_sel_nxt = 1'b0;
        next_nxt     = 1'b1;
        state_nxt    = S_INSTR_START;
      end
      S_INSTR_START:  state_nxt = S_INSTR;
      S_ADDR_START:   state_nxt = S_ADDR;
      S_DATA_START:   state_nxt = S_DATA;
      S_FINISH_START: state_nxt = S_FINISH;
      S_INSTR, S_ADDR, S_DATA: begin
        if (!comm_active) begin
          // Master aborted the transaction: stop injecting and wait for the next one.
          miso_sel_nxt = 1'b0;
          mosi_sel_nxt = 1'b0;
          state_nxt    = S_IDLE;
        end else if (bus_ready) begin
          if (state == S_INSTR) begin
            if (is_read) begin
              size_nxt  = SZ_ADDR;
              next_nxt  = 1'b1;
              state_nxt = S_ADDR_START;
              if (mode_q == MODE_REDIRECT) begin
                mosi_data_nxt = redir_word;
                mosi_sel_nxt  = 1'b1;
              end
            end else begin
              size_nxt  = '0;
              fin_nxt   = 1'b1;
              state_nxt = S_FINISH_START;
            end
          end else if (state == S_ADDR) begin
            mosi_sel_nxt = 1'b0;
            if (mode_q == MODE_SUB_HALF) half_nxt = ~half_toggle;
            if (mode_q == MODE_REDIRECT) cnt_nxt = sat_inc(sub_count);
            if (do_sub) begin
              size_nxt      = SZ_DATA;
              miso_data_nxt = miso_word;
              miso_sel_nxt  = 1'b1;
              next_nxt      = 1'b1;
              cnt_nxt       = sat_inc(sub_count);
              state_nxt     = S_DATA_START;
            end else begin
              size_nxt  = '0;
              fin_nxt   = 1'b1;
              state_nxt = S_FINISH_START;
            end
          end else begin
`ifdef MITM_SEQ_READ_EN
            size_nxt      = SZ_DATA;
            miso_data_nxt = miso_word;
            miso_sel_nxt  = 1'b1;
            next_nxt      = 1'b1;
            state_nxt     = S_DATA_START;
`else
            fin_nxt   = 1'b1;
            state_nxt = S_FINISH_START;
`endif
          end
        end
      end
      S_FINISH: if (!comm_active) begin
        miso_sel_nxt = 1'b0;
        mosi_sel_nxt = 1'b0;
        size_nxt     = '0;
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_RESET;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state            <= S_RESET;
      mode_q           <= '0;
      half_toggle      <= 1'b0;
      cmd_next_chunk   <= 1'b0;
      cmd_finish       <= 1'b0;
      next_chunk_size  <= '0;
      fake_miso_select <= 1'b0;
      fake_mosi_select <= 1'b0;
      fake_miso_data   <= '0;
      fake_mosi_data   <= '0;
      sub_count        <= '0;
    end else begin
      state            <= state_nxt;
      mode_q           <= mode_nxt;
      half_toggle      <= half_nxt;
      cmd_next_chunk   <= next_nxt;
      cmd_finish       <= fin_nxt;
      next_chunk_size  <= size_nxt;
      fake_miso_select <= miso_sel_nxt;
      fake_mosi_select <= mosi_sel_nxt;
      fake_miso_data   <= miso_data_nxt;
      fake_mosi_data   <= mosi_data_nxt;
      sub_count        <= cnt_nxt;
    end
  end

endmodule
